// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-add multiplier sequencer.
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_shift_add_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// accumulator half, then shift {carry, accumulator} right by one.
module mult_shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic               i_mplier_lsb,
    output logic [2*WIDTH-1:0] o_acc_next
);

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_wide;

    always_comb begin
        w_addend   = i_mplier_lsb ? i_mcand : '0;
        w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
        w_wide     = {w_sum, i_acc[WIDTH-1:0]};
        o_acc_next = w_wide[2*WIDTH:1];
    end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle sign-magnitude shift-add multiplier: WIDTH iterations in RUN,
// HI/LO written on the RUN->DONE edge, ProdVE pulsed while in DONE.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             MultStartE,
    input  logic             SignedE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             ProdVE,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int                  CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]    ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]  ONE_2W   = (2*WIDTH)'(1);

    mult_state_t         r_state;
    mult_state_t         w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic                r_neg;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;

    logic [WIDTH-1:0]    w_mag_a;
    logic [WIDTH-1:0]    w_mag_b;
    logic [2*WIDTH-1:0]  w_acc_next;
    logic [2*WIDTH-1:0]  w_result;
    logic                w_last_iter;

    // 0x80.. negates to itself, which is exactly 2^(WIDTH-1) read as unsigned.
    always_comb begin
        w_mag_a     = (SignedE && SrcAE[WIDTH-1]) ? (~SrcAE + ONE_W) : SrcAE;
        w_mag_b     = (SignedE && SrcBE[WIDTH-1]) ? (~SrcBE + ONE_W) : SrcBE;
        w_last_iter = (r_cnt == LAST_CNT);
        w_result    = r_neg ? (~w_acc_next + ONE_2W) : w_acc_next;
    end

    mult_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc        (r_acc),
        .i_mcand      (r_mcand),
        .i_mplier_lsb (r_mplier[0]),
        .o_acc_next   (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (MultStartE)  w_state_next = RUN;
            RUN:     if (w_last_iter) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy   = (r_state != IDLE);
        ProdVE = (r_state == DONE);
    end

    // Datapath: the final iteration's result goes straight into HI/LO so the
    // product is already stable when ProdVE rises a cycle later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (MultStartE) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_neg    <= SignedE & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_ONE;
                    if (w_last_iter) begin
                        r_hi <= w_result[2*WIDTH-1:WIDTH];
                        r_lo <= w_result[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: table of multiplies plus hand-written
// sequences for ignored restarts, back-to-back starts and mid-run reset.
module tb_mult_sequencer;

    logic        clk;
    logic        reset_n;
    logic        MultStartE;
    logic        SignedE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        ProdVE;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;

    mult_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .MultStartE (MultStartE),
        .SignedE    (SignedE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .ProdVE     (ProdVE),
        .Busy       (Busy),
        .HI         (HI),
        .LO         (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Called at the start of a cycle (1 time unit after the rising edge); that
    // cycle is cycle 0. Returns at the start of cycle 41.
    task automatic mult_run(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output int pulse_cyc, output int pulses, output int busy_cnt,
                            output logic [31:0] hi_at, output logic [31:0] lo_at,
                            output logic [31:0] hi_c1, output logic [31:0] lo_c1,
                            output logic busy_c0, output logic busy_c34);
        pulse_cyc = -1;
        pulses    = 0;
        busy_cnt  = 0;
        hi_at     = '0;
        lo_at     = '0;
        hi_c1     = '0;
        lo_c1     = '0;
        busy_c34  = 1'b1;
        MultStartE = 1'b1;
        SrcAE      = a;
        SrcBE      = b;
        SignedE    = s;
        @(negedge clk);
        busy_c0 = Busy;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            MultStartE = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                hi_c1 = HI;
                lo_c1 = LO;
            end
            if (c == 34) busy_c34 = Busy;
            if (Busy) busy_cnt++;
            if (ProdVE) begin
                pulses++;
                if (pulse_cyc < 0) begin
                    pulse_cyc = c;
                    hi_at     = HI;
                    lo_at     = LO;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          pulse_cyc, pulses, busy_cnt;
        logic [31:0] hi_at, lo_at, hi_c1, lo_c1;
        logic        busy_c0, busy_c34;
        logic [31:0] prev_hi, prev_lo;
        int          p_cyc[2];
        logic [31:0] p_lo[2];
        logic [31:0] p_hi[2];
        int          np;

        vecs[0] = '{name:"u7x6",      a:32'd7,          b:32'd6,          s:1'b0, hi:32'h00000000, lo:32'h0000002A};
        vecs[1] = '{name:"s-3x5",     a:32'hFFFFFFFD,   b:32'd5,          s:1'b1, hi:32'hFFFFFFFF, lo:32'hFFFFFFF1};
        vecs[2] = '{name:"u-3x5",     a:32'hFFFFFFFD,   b:32'd5,          s:1'b0, hi:32'h00000004, lo:32'hFFFFFFF1};
        vecs[3] = '{name:"uFFxFF",    a:32'hFFFFFFFF,   b:32'hFFFFFFFF,   s:1'b0, hi:32'hFFFFFFFE, lo:32'h00000001};
        vecs[4] = '{name:"s80x80",    a:32'h80000000,   b:32'h80000000,   s:1'b1, hi:32'h40000000, lo:32'h00000000};
        vecs[5] = '{name:"s7x-2",     a:32'd7,          b:32'hFFFFFFFE,   s:1'b1, hi:32'hFFFFFFFF, lo:32'hFFFFFFF2};
        vecs[6] = '{name:"u0x1234",   a:32'd0,          b:32'h12345678,   s:1'b0, hi:32'h00000000, lo:32'h00000000};
        vecs[7] = '{name:"u4x4",      a:32'd4,          b:32'd4,          s:1'b0, hi:32'h00000000, lo:32'h00000010};

        reset_n    = 1'b0;
        MultStartE = 1'b0;
        SignedE    = 1'b0;
        SrcAE      = '0;
        SrcBE      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_prodve", 64'(ProdVE), 64'd0);
        check("reset_busy",   64'(Busy),   64'd0);
        check("reset_hi",     64'(HI),     64'd0);
        check("reset_lo",     64'(LO),     64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        prev_hi = '0;
        prev_lo = '0;
        for (int i = 0; i < 8; i++) begin
            mult_run(vecs[i].a, vecs[i].b, vecs[i].s, pulse_cyc, pulses, busy_cnt,
                     hi_at, lo_at, hi_c1, lo_c1, busy_c0, busy_c34);
            $display("vec %s a=0x%08h b=0x%08h signed=%0d -> pulse@%0d HI=0x%08h LO=0x%08h",
                     vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, pulse_cyc, hi_at, lo_at);
            check({vecs[i].name, "_busy_c0"},   64'(busy_c0),   64'd0);
            check({vecs[i].name, "_pulse_cyc"}, 64'(pulse_cyc), 64'd33);
            check({vecs[i].name, "_pulses"},    64'(pulses),    64'd1);
            check({vecs[i].name, "_busy_cnt"},  64'(busy_cnt),  64'd33);
            check({vecs[i].name, "_busy_c34"},  64'(busy_c34),  64'd0);
            check({vecs[i].name, "_hold_hi"},   64'(hi_c1),     64'(prev_hi));
            check({vecs[i].name, "_hold_lo"},   64'(lo_c1),     64'(prev_lo));
            check({vecs[i].name, "_hi"},        64'(hi_at),     64'(vecs[i].hi));
            check({vecs[i].name, "_lo"},        64'(lo_at),     64'(vecs[i].lo));
            prev_hi = vecs[i].hi;
            prev_lo = vecs[i].lo;
        end

        // Start 5x5 after 4x4 completed; reset lands mid-RUN at cycle 10.
        pulses     = 0;
        MultStartE = 1'b1;
        SignedE    = 1'b0;
        SrcAE      = 32'd5;
        SrcBE      = 32'd5;
        @(negedge clk);
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            MultStartE = 1'b0;
            if (c == 10) reset_n = 1'b0;
            if (c == 11) reset_n = 1'b1;
            @(negedge clk);
            if (c == 10) begin
                check("rst_c10_busy", 64'(Busy), 64'd1);
                check("rst_c10_lo",   64'(LO),   64'd16);
            end
            if (c == 11) begin
                check("rst_c11_busy", 64'(Busy), 64'd0);
                check("rst_c11_hi",   64'(HI),   64'd0);
                check("rst_c11_lo",   64'(LO),   64'd0);
            end
            if (ProdVE) pulses++;
        end
        $display("seq reset_mid_run 5x5 -> pulses=%0d HI=0x%08h LO=0x%08h", pulses, HI, LO);
        check("rst_no_pulse", 64'(pulses), 64'd0);
        check("rst_end_lo",   64'(LO),     64'd0);
        @(posedge clk); #1;

        // 2x3 at cycle 0, 9x9 held during 5..20 (ignored), fresh 9x9 at 34.
        np = 0;
        for (int k = 0; k < 2; k++) begin
            p_cyc[k] = -1;
            p_lo[k]  = '0;
            p_hi[k]  = '0;
        end
        for (int c = 0; c <= 80; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            MultStartE = (c == 0) || (c >= 5 && c <= 20) || (c == 34);
            SrcAE      = (c == 0) ? 32'd2 : 32'd9;
            SrcBE      = (c == 0) ? 32'd3 : 32'd9;
            SignedE    = 1'b0;
            @(negedge clk);
            if (ProdVE) begin
                if (np < 2) begin
                    p_cyc[np] = c;
                    p_lo[np]  = LO;
                    p_hi[np]  = HI;
                end
                np++;
            end
        end
        MultStartE = 1'b0;
        $display("seq ignore_then_b2b -> pulses=%0d first@%0d LO=0x%08h second@%0d LO=0x%08h",
                 np, p_cyc[0], p_lo[0], p_cyc[1], p_lo[1]);
        check("b2b_pulses",    64'(np),       64'd2);
        check("b2b_first_cyc", 64'(p_cyc[0]), 64'd33);
        check("b2b_first_lo",  64'(p_lo[0]),  64'd6);
        check("b2b_first_hi",  64'(p_hi[0]),  64'd0);
        check("b2b_second_cyc",64'(p_cyc[1]), 64'd67);
        check("b2b_second_lo", 64'(p_lo[1]),  64'h51);
        check("b2b_second_hi", 64'(p_hi[1]),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
